// File: rtl/button_debouncer_if.sv
// Signal bundle between a raw push-button source and the debouncer.
// The master drives the raw level; the slave returns the conditioned level, strobes and busy.
interface button_debouncer_if;
  logic btn_in;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  btn_in,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: a multi-flop synchronizer followed by a counter-qualified
// four-state FSM producing a clean level plus single-cycle rise/fall strobes.
module button_debouncer #(
  parameter int       SYNC_STAGES     = 2,
  parameter int       DEBOUNCE_CYCLES = 1000000,
  parameter int       CNT_WIDTH       = 20,
  parameter bit       RESET_LEVEL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  localparam state_t                 RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE     = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   r_level;
  logic                   w_level_next;
  logic                   r_rise;
  logic                   w_rise_next;
  logic                   r_fall;
  logic                   w_fall_next;
  logic                   r_busy;
  logic                   w_busy_next;

  // Raw pin goes straight into stage 0 with no logic in front of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      r_busy  <= w_busy_next;
    end
  end

  // Counter is cleared on every path except continued qualification, so it never wraps.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_level_next = r_level;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;

    case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_state_next = CHECK_HI;
          w_cnt_next   = CNT_ONE;
        end
      end
      CHECK_HI: begin
        if (!w_s) begin
          w_state_next = STABLE_LO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = STABLE_HI;
          w_level_next = 1'b1;
          w_rise_next  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_state_next = CHECK_LO;
          w_cnt_next   = CNT_ONE;
        end
      end
      CHECK_LO: begin
        if (w_s) begin
          w_state_next = STABLE_HI;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = STABLE_LO;
          w_level_next = 1'b0;
          w_fall_next  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = RESET_STATE;
        w_level_next = RESET_LEVEL;
      end
    endcase

    w_busy_next = (w_state_next == CHECK_HI) || (w_state_next == CHECK_LO);
  end

  assign bus.level_out  = r_level;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=8: reset,
// clean press, bounce, short glitch, release and reset during qualification.
module tb_button_debouncer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_rise_seen;
  int   n_fall_seen;

  button_debouncer_if bus_if ();

  button_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .CNT_WIDTH       (4),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  // Advance one edge and sample 1 ns later; strobes are tallied and must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_if.rise_pulse) n_rise_seen++;
    if (bus_if.fall_pulse) n_fall_seen++;
    if (bus_if.rise_pulse && bus_if.fall_pulse) begin
      check("strobe_exclusive", 32'(bus_if.rise_pulse & bus_if.fall_pulse), 32'd0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    n_rise_seen    = 0;
    n_fall_seen    = 0;
    rst            = 1'b1;
    bus_if.btn_in  = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();
    check("reset_level",  32'(bus_if.level_out),  32'd0);
    check("reset_rise",   32'(bus_if.rise_pulse), 32'd0);
    check("reset_fall",   32'(bus_if.fall_pulse), 32'd0);
    check("reset_busy",   32'(bus_if.busy),       32'd0);

    // Clean press: busy on edges 3..9, accept on edge 10, strobe gone on 11.
    bus_if.btn_in = 1'b1;
    n_rise_seen = 0;
    ticks(2);
    check("press_busy_e2", 32'(bus_if.busy), 32'd0);
    tick();
    check("press_busy_e3", 32'(bus_if.busy), 32'd1);
    ticks(6);
    check("press_busy_e9",  32'(bus_if.busy),      32'd1);
    check("press_level_e9", 32'(bus_if.level_out), 32'd0);
    check("press_early_rise", 32'(n_rise_seen),    32'd0);
    tick();
    check("press_level_e10", 32'(bus_if.level_out),  32'd1);
    check("press_rise_e10",  32'(bus_if.rise_pulse), 32'd1);
    check("press_busy_e10",  32'(bus_if.busy),       32'd0);
    tick();
    check("press_rise_e11",  32'(bus_if.rise_pulse), 32'd0);
    check("press_level_e11", 32'(bus_if.level_out),  32'd1);

    // Asynchronous reset with the button held: outputs clear before any edge.
    rst = 1'b1;
    #1;
    check("async_rst_level", 32'(bus_if.level_out), 32'd0);
    check("async_rst_busy",  32'(bus_if.busy),      32'd0);
    bus_if.btn_in = 1'b0;
    ticks(2);
    rst = 1'b0;
    n_rise_seen = 0;
    n_fall_seen = 0;
    ticks(12);
    check("post_rst_level", 32'(bus_if.level_out), 32'd0);
    check("post_rst_strobes", 32'(n_rise_seen + n_fall_seen), 32'd0);

    // Bounce: 3-cycle toggles for 30 cycles, then a steady press.
    n_rise_seen = 0;
    for (int p = 0; p < 5; p++) begin
      bus_if.btn_in = 1'b1;
      ticks(3);
      bus_if.btn_in = 1'b0;
      ticks(3);
    end
    check("bounce_no_rise",  32'(n_rise_seen),      32'd0);
    check("bounce_level",    32'(bus_if.level_out), 32'd0);
    bus_if.btn_in = 1'b1;
    ticks(9);
    check("bounce_hold_e9", 32'(bus_if.level_out), 32'd0);
    tick();
    check("bounce_rise_e10",  32'(bus_if.rise_pulse), 32'd1);
    check("bounce_level_e10", 32'(bus_if.level_out),  32'd1);
    check("bounce_one_rise",  32'(n_rise_seen),       32'd1);

    // Release from the high level: single fall strobe on edge 10.
    bus_if.btn_in = 1'b0;
    n_fall_seen = 0;
    ticks(9);
    check("release_level_e9", 32'(bus_if.level_out),  32'd1);
    check("release_busy_e9",  32'(bus_if.busy),       32'd1);
    tick();
    check("release_fall_e10",  32'(bus_if.fall_pulse), 32'd1);
    check("release_level_e10", 32'(bus_if.level_out),  32'd0);
    tick();
    check("release_fall_e11", 32'(bus_if.fall_pulse), 32'd0);
    check("release_one_fall", 32'(n_fall_seen),       32'd1);

    // Short glitch: 5 cycles high is rejected and busy returns low.
    n_rise_seen = 0;
    bus_if.btn_in = 1'b1;
    ticks(5);
    check("glitch_busy_e5", 32'(bus_if.busy), 32'd1);
    bus_if.btn_in = 1'b0;
    ticks(6);
    check("glitch_busy_end",  32'(bus_if.busy),      32'd0);
    check("glitch_level",     32'(bus_if.level_out), 32'd0);
    check("glitch_no_rise",   32'(n_rise_seen),      32'd0);

    // Reset during CHECK_HI discards the candidate; qualification restarts from scratch.
    bus_if.btn_in = 1'b1;
    ticks(6);
    check("midchk_busy_e6", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midchk_rst_cnt",   32'(dut.r_cnt),        32'd0);
    check("midchk_rst_level", 32'(bus_if.level_out), 32'd0);
    check("midchk_rst_busy",  32'(bus_if.busy),      32'd0);
    ticks(2);
    rst = 1'b0;
    n_rise_seen = 0;
    ticks(9);
    check("midchk_level_e9", 32'(bus_if.level_out), 32'd0);
    check("midchk_no_early", 32'(n_rise_seen),      32'd0);
    tick();
    check("midchk_rise_e10",  32'(bus_if.rise_pulse), 32'd1);
    check("midchk_level_e10", 32'(bus_if.level_out),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
